// File: rtl/unita_ctrl_5.sv
// Weight-load and per-slice fetch/stream sequencer for one 5x5 conv unit.
// Optional UNITA_CTRL_IFM_HANDSHAKE_EN: ifm_valid gates pixel acceptance.
module unita_ctrl_5 #(
    parameter int IFM_SIZE          = 5,
    parameter int KERNAL_SIZE       = 5,
    parameter int NUMBER_OF_FILTERS = 100,
    parameter int CEIL_DEPTH        = 10,
    parameter int ADDRESS_SIZE_WM   =
        $clog2(KERNAL_SIZE * KERNAL_SIZE * NUMBER_OF_FILTERS * CEIL_DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wm_load,
    input  logic                       riscv_wr_valid,
    input  logic                       start,
    input  logic                       ifm_valid,
    output logic                       ifm_ready,
    output logic [ADDRESS_SIZE_WM-1:0] wm_address,
    output logic                       wm_enable_write,
    output logic                       wm_enable_read,
    output logic                       wm_fifo_enable,
    output logic                       fifo_enable,
    output logic                       conv_enable,
    output logic                       busy,
    output logic                       load_done,
    output logic                       done
);

    localparam int KK    = KERNAL_SIZE * KERNAL_SIZE;
    localparam int TOTAL = KK * NUMBER_OF_FILTERS * CEIL_DEPTH;
    localparam int AW    = ADDRESS_SIZE_WM;
    localparam int WW    = $clog2(TOTAL) + 1;
    localparam int KW    = $clog2(KK) + 1;
    localparam int FW    = $clog2(NUMBER_OF_FILTERS) + 1;
    localparam int DW    = $clog2(CEIL_DEPTH) + 1;
    localparam int PW    = $clog2(IFM_SIZE) + 1;

    localparam logic [WW-1:0] WR_END   = WW'(TOTAL);
    localparam logic [KW-1:0] K_LAST   = KW'(KK - 1);
    localparam logic [FW-1:0] F_LAST   = FW'(NUMBER_OF_FILTERS - 1);
    localparam logic [DW-1:0] D_LAST   = DW'(CEIL_DEPTH - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(IFM_SIZE - 1);
    localparam logic [PW-1:0] WIN_MIN  = PW'(KERNAL_SIZE - 1);
    localparam logic [AW-1:0] SLICE_SZ = AW'(KK);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_STREAM,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] wr_cnt;
    logic [KW-1:0] k_cnt;
    logic [FW-1:0] filter;
    logic [DW-1:0] depth;
    logic [PW-1:0] row;
    logic [PW-1:0] col;
    logic [AW-1:0] base;
    logic          rd_q;
    logic          conv_q;
    logic          pix_ok;
    logic          accept;
    logic          slice_end;
    logic          pass_end;
    logic          win_ok;

`ifdef UNITA_CTRL_IFM_HANDSHAKE_EN
    assign pix_ok = ifm_valid;
`else
    logic ifm_valid_unused;
    assign ifm_valid_unused = ifm_valid;
    assign pix_ok           = 1'b1;
`endif

    assign slice_end = (row == P_LAST) && (col == P_LAST);
    assign pass_end  = slice_end && (depth == D_LAST) && (filter == F_LAST);
    assign win_ok    = (row >= WIN_MIN) && (col >= WIN_MIN);

    assign wm_fifo_enable = rd_q;
    assign conv_enable    = conv_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wm_address      = '0;
        wm_enable_write = 1'b0;
        wm_enable_read  = 1'b0;
        ifm_ready       = 1'b0;
        fifo_enable     = 1'b0;
        load_done       = 1'b0;
        done            = 1'b0;
        busy            = 1'b1;
        accept          = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (wm_load) begin
                    state_nxt = S_LOAD;
                end else if (start) begin
                    state_nxt = S_FETCH;
                end
            end
            S_LOAD: begin
                if (wr_cnt == WR_END) begin
                    load_done = 1'b1;
                    state_nxt = S_IDLE;
                end else if (riscv_wr_valid) begin
                    wm_enable_write = 1'b1;
                    wm_address      = wr_cnt[AW-1:0];
                end
            end
            S_FETCH: begin
                wm_enable_read = 1'b1;
                wm_address     = base + AW'(k_cnt);
                if (k_cnt == K_LAST) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                ifm_ready   = 1'b1;
                accept      = pix_ok;
                fifo_enable = pix_ok;
                if (pix_ok && pass_end) begin
                    state_nxt = S_DONE;
                end else if (pix_ok && slice_end) begin
                    state_nxt = S_FETCH;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt <= '0;
            k_cnt  <= '0;
            filter <= '0;
            depth  <= '0;
            row    <= '0;
            col    <= '0;
            base   <= '0;
            rd_q   <= 1'b0;
            conv_q <= 1'b0;
        end else begin
            rd_q   <= wm_enable_read;
            conv_q <= accept && win_ok;
            unique case (state)
                S_IDLE: begin
                    k_cnt  <= '0;
                    filter <= '0;
                    depth  <= '0;
                    row    <= '0;
                    col    <= '0;
                    base   <= '0;
                end
                S_LOAD: begin
                    if (wr_cnt == WR_END) begin
                        wr_cnt <= '0;
                    end else if (riscv_wr_valid) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                S_FETCH: begin
                    k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
                end
                S_STREAM: begin
                    if (accept) begin
                        if (col != P_LAST) begin
                            col <= col + 1'b1;
                        end else if (row != P_LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            // slice finished: advance to next (filter, depth)
                            col  <= '0;
                            row  <= '0;
                            base <= base + SLICE_SZ;
                            if (depth == D_LAST) begin
                                depth  <= '0;
                                filter <= (filter == F_LAST) ? '0 : filter + 1'b1;
                            end else begin
                                depth <= depth + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unita_ctrl_5.sv
// Directed bench for unita_ctrl_5 with a per-cycle expected-output queue.
// Runs K=5, IFM=5, F=2, D=2 (100 weights, 4 slices).
module tb_unita_ctrl_5;

    localparam int K   = 5;
    localparam int IFM = 5;
    localparam int F   = 2;
    localparam int D   = 2;
    localparam int KK  = K * K;
    localparam int PIX = IFM * IFM;
    localparam int S   = F * D;
    localparam int TOT = KK * F * D;
    localparam int AW  = $clog2(TOT);
`ifdef UNITA_CTRL_IFM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    typedef struct packed {
        logic          rdy;
        logic [AW-1:0] addr;
        logic          we;
        logic          re;
        logic          wfe;
        logic          fe;
        logic          ce;
        logic          busy;
        logic          ld;
        logic          dn;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wm_load = 1'b0;
    logic          riscv_wr_valid = 1'b0;
    logic          start = 1'b0;
    logic          ifm_valid = 1'b0;
    logic          ifm_ready;
    logic [AW-1:0] wm_address;
    logic          wm_enable_write;
    logic          wm_enable_read;
    logic          wm_fifo_enable;
    logic          fifo_enable;
    logic          conv_enable;
    logic          busy;
    logic          load_done;
    logic          done;

    unita_ctrl_5 #(
        .IFM_SIZE(IFM),
        .KERNAL_SIZE(K),
        .NUMBER_OF_FILTERS(F),
        .CEIL_DEPTH(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wm_load(wm_load),
        .riscv_wr_valid(riscv_wr_valid),
        .start(start),
        .ifm_valid(ifm_valid),
        .ifm_ready(ifm_ready),
        .wm_address(wm_address),
        .wm_enable_write(wm_enable_write),
        .wm_enable_read(wm_enable_read),
        .wm_fifo_enable(wm_fifo_enable),
        .fifo_enable(fifo_enable),
        .conv_enable(conv_enable),
        .busy(busy),
        .load_done(load_done),
        .done(done)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   cyc = 0;
    int   n_we, n_re, n_wfe, n_fe, n_ce, n_done, n_ld;
    int   last_we_addr, last_we_at, ld_at, done_at;
    int   bases[$];
    logic prev_re = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{rdy: ifm_ready, addr: wm_address, we: wm_enable_write,
                  re: wm_enable_read, wfe: wm_fifo_enable, fe: fifo_enable,
                  ce: conv_enable, busy: busy, ld: load_done, dn: done};
            if (!(e.we || e.re)) begin
                a.addr = '0;
                e.addr = '0;
            end
            vectors++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle %0d outputs: got %h, want %h", cyc, a, e);
            end
        end
        if (wm_enable_write) begin
            n_we++;
            last_we_addr = int'(wm_address);
            last_we_at   = cyc;
        end
        if (wm_enable_read) n_re++;
        if (wm_enable_read && !prev_re) bases.push_back(int'(wm_address));
        if (wm_fifo_enable) n_wfe++;
        if (fifo_enable) n_fe++;
        if (conv_enable) n_ce++;
        if (load_done) begin
            n_ld++;
            ld_at = cyc;
        end
        if (done) begin
            n_done++;
            done_at = cyc;
        end
        prev_re = wm_enable_read;
        cyc++;
    end

    task automatic check(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    task automatic clr_mon();
        n_we = 0; n_re = 0; n_wfe = 0; n_fe = 0; n_ce = 0;
        n_done = 0; n_ld = 0;
        last_we_addr = -1; last_we_at = -1; ld_at = -1; done_at = -1;
        bases.delete();
    endtask

    task automatic step(input logic rs, ld, wv, st, iv, input exp_t e);
        @(posedge clk);
        #1;
        reset          = rs;
        wm_load        = ld;
        riscv_wr_valid = wv;
        start          = st;
        ifm_valid      = iv;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    task automatic run_load(input bit with_start);
        exp_t e;
        int   n;
        int   i;
        bit   wv;
        clr_mon();
        e = '0;
        step(1, 1, 0, with_start, 1, e);
        n = 0;
        i = 0;
        while (n < TOT && i < 1000) begin
            wv = (i % 5) != 2;
            e = '0;
            e.busy = 1'b1;
            e.we   = wv;
            e.addr = AW'(n);
            step(1, i < 3, wv, with_start && i == 1, 1, e);
            if (wv) n++;
            i++;
        end
        e = '0;
        e.ld   = 1'b1;
        e.busy = 1'b1;
        step(1, 0, 0, 0, 1, e);
        e = '0;
        step(1, 0, 0, 0, 1, e);
        drain();
        check("load_writes", n_we, 100);
        check("load_last_addr", last_we_addr, 99);
        check("load_done_lat", ld_at - last_we_at, 1);
        check("load_done_cnt", n_ld, 1);
        check("load_reads", n_re, 0);
    endtask

    task automatic run_pass(input int ss, sp, sn, input bit poke,
                            input int ab_s, input int lat);
        exp_t e;
        bit   pce;
        bit   iv;
        bit   acc;
        bit   st;
        int   p;
        int   c;
        int   stl;
        int   t0;
        clr_mon();
        e = '0;
        step(1, 0, 0, 1, 1, e);
        t0  = cyc;
        pce = 1'b0;
        for (int s = 0; s < S; s++) begin
            for (int k = 0; k < KK; k++) begin
                if (s == ab_s && k == 10) begin
                    e = '0;
                    step(0, 0, 0, 0, 1, e);
                    return;
                end
                e = '0;
                e.re   = 1'b1;
                e.addr = AW'(s * KK + k);
                e.wfe  = k > 0;
                e.ce   = (k == 0) && pce;
                e.busy = 1'b1;
                st = poke && s == 0 && k == 3;
                step(1, 0, 0, st, 1, e);
                pce = 1'b0;
            end
            p   = 0;
            c   = 0;
            stl = 0;
            while (p < PIX) begin
                iv = !(s == ss && p == sp && stl < sn);
                if (!iv) stl++;
                acc = HS ? iv : 1'b1;
                e = '0;
                e.rdy  = 1'b1;
                e.fe   = acc;
                e.wfe  = c == 0;
                e.ce   = pce;
                e.busy = 1'b1;
                st = poke && s == 2 && p == 10;
                step(1, 0, 0, st, iv, e);
                pce = acc && (p / IFM >= K - 1) && (p % IFM >= K - 1);
                if (acc) p++;
                c++;
            end
        end
        e = '0;
        e.dn   = 1'b1;
        e.busy = 1'b1;
        e.ce   = pce;
        step(1, 0, 0, poke, 1, e);
        e = '0;
        step(1, 0, 0, 0, 1, e);
        drain();
        check("pass_reads", n_re, 100);
        check("pass_wfifo", n_wfe, 100);
        check("pass_ffifo", n_fe, 100);
        check("pass_conv", n_ce, 4);
        check("pass_done_cnt", n_done, 1);
        check("pass_done_lat", done_at - t0, lat);
        check("pass_bursts", bases.size(), 4);
        for (int b = 0; b < bases.size(); b++) begin
            check("pass_base", bases[b], b * 25);
        end
    endtask

    initial begin
        exp_t z;
        z = '0;
        step(0, 0, 0, 0, 0, z);
        step(0, 0, 0, 1, 1, z);
        step(1, 0, 0, 0, 0, z);
        run_load(1'b0);
        run_pass(-1, 0, 0, 1'b0, -1, 201);
        run_pass(1, 12, 3, 1'b0, -1, HS ? 204 : 201);
        run_load(1'b1);
        run_pass(-1, 0, 0, 1'b0, 1, 0);
        step(0, 0, 0, 1, 1, z);
        step(1, 0, 0, 0, 1, z);
        drain();
        check("abort_done", n_done, 0);
        check("abort_bases", bases.size(), 2);
        run_pass(-1, 0, 0, 1'b0, -1, 201);
        run_pass(-1, 0, 0, 1'b1, -1, 201);
        drain();
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
